// File: rtl/oven_timer_ctrl.sv
// Oven timer sequencer: keypad capture, countdown gating and cook/pause/done FSM.
// Ports: i_clock, i_clear (sync reset), i_tick, i_start, i_stop, i_door_closed,
//   i_key_valid/i_key_digit, i_zero_* from the digits; o_data_*, o_loadn,
//   o_clearn_out, o_count_en to the digits; o_heater, o_done to the panel.
module oven_timer_ctrl (
  input  logic       i_clock,
  input  logic       i_clear,
  input  logic       i_tick,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_door_closed,
  input  logic       i_key_valid,
  input  logic [3:0] i_key_digit,
  input  logic       i_zero_mins,
  input  logic       i_zero_tens,
  input  logic       i_zero_ones,
  output logic [3:0] o_data_mins,
  output logic [3:0] o_data_tens,
  output logic [3:0] o_data_ones,
  output logic       o_loadn,
  output logic       o_clearn_out,
  output logic       o_count_en,
  output logic       o_heater,
  output logic       o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET,
    S_COOK,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_heater;
  logic       r_loadn;
  logic       r_clearn;
  logic [3:0] r_data_mins;
  logic [3:0] r_data_tens;
  logic [3:0] r_data_ones;

  logic w_all_zero;
  logic w_key_ok;
  logic w_go;
  logic w_cancel;
  logic w_load;

  assign w_all_zero = i_zero_mins & i_zero_tens & i_zero_ones;
  assign w_key_ok   = i_key_valid & (i_key_digit <= 4'd9);
  // start from SET only with a closed door and a nonzero time
  assign w_go       = i_start & i_door_closed & ~w_all_zero;

  // state register; heater is registered alongside it
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_state  <= S_IDLE;
      r_heater <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_heater <= (w_next == S_COOK);
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (!i_stop && w_key_ok)
          w_next = S_SET;
      end
      S_SET: begin
        if (i_stop)
          w_next = S_IDLE;
        else if (w_go)
          w_next = S_COOK;
      end
      S_COOK: begin
        if (i_stop || !i_door_closed)
          w_next = S_PAUSE;
        else if (w_all_zero)
          w_next = S_DONE;
      end
      S_PAUSE: begin
        if (i_stop)
          w_next = S_IDLE;
        else if (i_start && i_door_closed)
          w_next = S_COOK;
      end
      S_DONE: begin
        if (i_stop || i_key_valid)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // output / event decode
  always_comb begin
    w_cancel   = 1'b0;
    w_load     = 1'b0;
    o_done     = (r_state == S_DONE);
    // gated at 000 so the chain can never wrap to 999
    o_count_en = (r_state == S_COOK) & i_tick
               & ~w_all_zero & ~i_clear;
    unique case (r_state)
      S_IDLE: begin
        w_cancel = i_stop;
        w_load   = ~i_stop & w_key_ok;
      end
      S_SET: begin
        w_cancel = i_stop;
        w_load   = ~i_stop & ~w_go & w_key_ok;
      end
      S_PAUSE: begin
        w_cancel = i_stop;
      end
      S_DONE: begin
        w_cancel = i_stop | i_key_valid;
      end
      default: begin
        w_cancel = 1'b0;
        w_load   = 1'b0;
      end
    endcase
  end

  // digit load data and the registered loadn / clearn strobes
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_data_mins <= 4'd0;
      r_data_tens <= 4'd0;
      r_data_ones <= 4'd0;
      r_loadn     <= 1'b1;
      r_clearn    <= 1'b0;
    end else begin
      r_loadn  <= ~w_load;
      r_clearn <= ~w_cancel;
      if (w_cancel) begin
        r_data_mins <= 4'd0;
        r_data_tens <= 4'd0;
        r_data_ones <= 4'd0;
      end else if (w_load) begin
        r_data_mins <= r_data_tens;
        r_data_tens <= r_data_ones;
        r_data_ones <= i_key_digit;
      end
    end
  end

  assign o_data_mins  = r_data_mins;
  assign o_data_tens  = r_data_tens;
  assign o_data_ones  = r_data_ones;
  assign o_loadn      = r_loadn;
  assign o_clearn_out = r_clearn;
  assign o_heater     = r_heater;

endmodule

// File: tb/tb_oven_timer_ctrl.sv
// Bench for oven_timer_ctrl with a behavioural three-digit BCD down-counter
// chain; expected values are queued with stimulus and checked at sample time.
module tb_oven_timer_ctrl;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       door = 1'b1;
  logic       kv = 1'b0;
  logic [3:0] kd = 4'd0;
  logic [3:0] dm, dt, dn;
  logic       loadn, clearn, cen, heater, done;
  logic [3:0] cm = 4'd0, ct = 4'd0, co = 4'd0;

  always #5 clk = ~clk;

  oven_timer_ctrl dut (
    .i_clock      (clk),
    .i_clear      (clear),
    .i_tick       (tick),
    .i_start      (start),
    .i_stop       (stop),
    .i_door_closed(door),
    .i_key_valid  (kv),
    .i_key_digit  (kd),
    .i_zero_mins  (cm == 4'd0),
    .i_zero_tens  (ct == 4'd0),
    .i_zero_ones  (co == 4'd0),
    .o_data_mins  (dm),
    .o_data_tens  (dt),
    .o_data_ones  (dn),
    .o_loadn      (loadn),
    .o_clearn_out (clearn),
    .o_count_en   (cen),
    .o_heater     (heater),
    .o_done       (done)
  );

  // digit chain: async clear, sync load, decimal borrow via tc chain
  always @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      cm <= 4'd0; ct <= 4'd0; co <= 4'd0;
    end else if (!loadn) begin
      cm <= dm; ct <= dt; co <= dn;
    end else if (cen) begin
      if (co == 4'd0) begin
        co <= 4'd9;
        if (ct == 4'd0) begin
          ct <= 4'd9;
          cm <= (cm == 4'd0) ? 4'd9 : cm - 4'd1;
        end else begin
          ct <= ct - 4'd1;
        end
      end else begin
        co <= co - 4'd1;
      end
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] v;
  } sb_t;

  sb_t sb[$];
  int  n_chk = 0;
  int  n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic void want(input string t, input logic [31:0] v);
    sb.push_back('{tag: t, v: v});
  endfunction

  function automatic logic [31:0] obs(input string t);
    case (t)
      "digits": obs = {20'd0, cm, ct, co};
      "data":   obs = {20'd0, dm, dt, dn};
      "loadn":  obs = {31'd0, loadn};
      "clearn": obs = {31'd0, clearn};
      "heater": obs = {31'd0, heater};
      "done":   obs = {31'd0, done};
      "cnt_en": obs = {31'd0, cen};
      default:  obs = 32'hdead;
    endcase
  endfunction

  task automatic drain();
    sb_t e;
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.tag), e.v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic key(input logic [3:0] d);
    kv = 1'b1; kd = d;
    cyc(1);
    kv = 1'b0;
  endtask

  task automatic tk();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  initial begin
    // power-on reset
    cyc(2);
    want("clearn", 0); want("heater", 0); want("done", 0);
    want("loadn", 1); want("data", 0); want("cnt_en", 0);
    drain();
    clear = 1'b0;
    cyc(1);
    want("clearn", 1); drain();

    // load 1:23, cook, then reset mid-count
    key(1); want("data", 'h001); want("loadn", 0); drain();
    key(2); want("data", 'h012); want("loadn", 0); drain();
    key(3); want("data", 'h123); want("loadn", 0); drain();
    cyc(1); want("loadn", 1); want("digits", 'h123); drain();
    go(); want("heater", 1); drain();
    tick = 1'b1; want("cnt_en", 1); drain();
    cyc(1); tick = 1'b0; want("digits", 'h122); drain();
    clear = 1'b1; tick = 1'b1;
    want("cnt_en", 0); drain();
    cyc(1); tick = 1'b0;
    want("heater", 0); want("clearn", 0); want("digits", 0);
    want("data", 0); want("done", 0); drain();
    cyc(1); clear = 1'b0;
    cyc(1); want("clearn", 1); want("digits", 0); drain();

    // entry 1,3,0 and an out-of-range key
    key(1); key(3); key(0);
    want("data", 'h130); want("loadn", 0); drain();
    key(4'd12);
    want("loadn", 1); want("data", 'h130); want("digits", 'h130);
    drain();
    cyc(1); want("loadn", 1); want("data", 'h130); drain();

    // stop in SET cancels
    halt();
    want("data", 0); want("clearn", 0); want("digits", 0); drain();
    cyc(1); want("clearn", 1); drain();

    // guards: start at 000, start with door open, start+stop
    key(0); cyc(1);
    go(); want("heater", 0); drain();
    key(5); cyc(1); want("digits", 'h005); drain();
    door = 1'b0; go(); want("heater", 0); drain();
    door = 1'b1;
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
    want("heater", 0); want("clearn", 0); want("data", 0); drain();
    cyc(1);

    // countdown 0:0:3 to DONE
    key(0); key(0); key(3); cyc(1);
    go(); want("heater", 1); drain();
    for (int i = 0; i < 3; i++) begin
      tk(); want("digits", 2 - i); drain();
    end
    want("heater", 1); want("done", 0); drain();
    cyc(1); want("heater", 0); want("done", 1); drain();
    tick = 1'b1; want("cnt_en", 0); drain();
    cyc(1); tick = 1'b0;
    want("digits", 0); want("done", 1); drain();
    key(7);
    want("done", 0); want("clearn", 0); want("loadn", 1);
    want("data", 0); drain();
    cyc(1);

    // borrow 1:00 -> 0:99, then stop pauses and stop cancels
    key(1); key(0); key(0); cyc(1);
    go(); tk(); want("digits", 'h099); drain();
    halt(); want("heater", 0); want("clearn", 1); drain();
    halt(); want("clearn", 0); want("data", 0); drain();
    cyc(1);

    // pause by door at 0:45, resume, door-open tick still counts
    key(0); key(4); key(5); cyc(1);
    go(); want("heater", 1); drain();
    door = 1'b0; cyc(1); want("heater", 0); drain();
    tick = 1'b1; want("cnt_en", 0); drain();
    cyc(1); tick = 1'b0; want("digits", 'h045); drain();
    door = 1'b1; go(); want("heater", 1); drain();
    tk(); want("digits", 'h044); drain();
    door = 1'b0; tk();
    want("heater", 0); want("digits", 'h043); drain();
    door = 1'b1;
    halt();
    want("data", 0); want("clearn", 0); want("digits", 0);
    want("heater", 0); drain();
    cyc(1); want("clearn", 1); drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
